// File: rtl/fwd_hazard_unit_pkg.sv
// Shared definitions for the operand-forwarding / hazard unit:
// write-source select encodings, FSM state encodings and the
// per-port forwarding source enumeration.
package fwd_hazard_unit_pkg;

    // EX write-source select encodings (only these two forward from EX)
    localparam logic [1:0] WRREG_ALURESULT = 2'b00;
    localparam logic [1:0] WRREG_IMMDATA   = 2'b01;

    // Outstanding-load tracker states
    typedef enum logic {
        FWD_IDLE = 1'b0,
        FWD_WAIT = 1'b1
    } fwd_state_e;

    // Which producer a single read port ends up taking its operand from
    typedef enum logic [2:0] {
        SRC_RF     = 3'd0,
        SRC_EX_ALU = 3'd1,
        SRC_EX_IMM = 3'd2,
        SRC_LOAD   = 3'd3,
        SRC_MEM    = 3'd4,
        SRC_WB     = 3'd5
    } fwd_src_e;

endpackage

// File: rtl/fwd_port_mux.sv
// Single read-port forwarding priority mux.
// Priority: EX (non-load, ALU/IMM select) > returning load > MEM > WB > regfile.
// Also reports raw address matches against the EX destination and the
// pending-load destination so the top can build the stall terms.
import fwd_hazard_unit_pkg::*;

module fwd_port_mux #(
    parameter int AW       = 5,
    parameter int DW       = 32,
    parameter int ZERO_REG = 1
) (
    input  logic [AW-1:0] rd_addr,
    input  logic [DW-1:0] rd_data,
    input  logic          ex_fwd_en,
    input  logic [1:0]    ex_wr_sel,
    input  logic [AW-1:0] ex_wr_addr,
    input  logic [DW-1:0] ex_imm,
    input  logic [DW-1:0] ex_alu,
    input  logic          ld_fwd_en,
    input  logic          pend_valid,
    input  logic [AW-1:0] pend_addr,
    input  logic [DW-1:0] dm_rdata,
    input  logic          mem_wr_en,
    input  logic [AW-1:0] mem_wr_addr,
    input  logic [DW-1:0] mem_wr_data,
    input  logic          wb_wr_en,
    input  logic [AW-1:0] wb_wr_addr,
    input  logic [DW-1:0] wb_wr_data,
    output logic [DW-1:0] fwd_data,
    output logic          fwd_hit,
    output logic          ex_match,
    output logic          pend_match
);

    fwd_src_e src;

    // Register 0 is hard-wired when ZERO_REG is set, so it never matches
    function automatic logic addr_match(input logic [AW-1:0] a, input logic [AW-1:0] b);
        return (a == b) && !((ZERO_REG != 0) && (a == '0));
    endfunction

    assign ex_match   = addr_match(rd_addr, ex_wr_addr);
    assign pend_match = pend_valid && addr_match(rd_addr, pend_addr);

    // Pick the youngest producer that writes this port's register
    always_comb begin
        src = SRC_RF;
        if (ex_fwd_en && ex_match && (ex_wr_sel == WRREG_ALURESULT)) begin
            src = SRC_EX_ALU;
        end else if (ex_fwd_en && ex_match && (ex_wr_sel == WRREG_IMMDATA)) begin
            src = SRC_EX_IMM;
        end else if (ld_fwd_en && pend_match) begin
            src = SRC_LOAD;
        end else if (mem_wr_en && addr_match(rd_addr, mem_wr_addr)) begin
            src = SRC_MEM;
        end else if (wb_wr_en && addr_match(rd_addr, wb_wr_addr)) begin
            src = SRC_WB;
        end
    end

    // Route the chosen producer's data onto the port
    always_comb begin
        fwd_data = rd_data;
        case (src)
            SRC_EX_ALU: fwd_data = ex_alu;
            SRC_EX_IMM: fwd_data = ex_imm;
            SRC_LOAD:   fwd_data = dm_rdata;
            SRC_MEM:    fwd_data = mem_wr_data;
            SRC_WB:     fwd_data = wb_wr_data;
            default:    fwd_data = rd_data;
        endcase
    end

    assign fwd_hit = (src != SRC_RF);

endmodule

// File: rtl/fwd_hazard_unit.sv
// Operand-forwarding and hazard unit for the 5-stage core.
// Forwards to NUM_RD ID read ports, tracks one outstanding variable-latency
// load, raises ID/EX stalls and a sticky memory timeout flag.
// Optional build macro FWD_PERF_CNT_EN adds stall/forward event counters.
import fwd_hazard_unit_pkg::*;

module fwd_hazard_unit #(
    parameter int NUM_RD   = 3,
    parameter int AW       = 5,
    parameter int DW       = 32,
    parameter int MAX_WAIT = 15,
    parameter int ZERO_REG = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_RD*AW-1:0] rd_addr,
    input  logic [NUM_RD*DW-1:0] rd_data,
    input  logic                 ex_wr_en,
    input  logic                 ex_dm_read,
    input  logic [1:0]           ex_wr_sel,
    input  logic [AW-1:0]        ex_wr_addr,
    input  logic [DW-1:0]        ex_imm,
    input  logic [DW-1:0]        ex_alu,
    input  logic                 mem_wr_en,
    input  logic [AW-1:0]        mem_wr_addr,
    input  logic [DW-1:0]        mem_wr_data,
    input  logic                 wb_wr_en,
    input  logic [AW-1:0]        wb_wr_addr,
    input  logic [DW-1:0]        wb_wr_data,
    input  logic                 dm_valid,
    input  logic [DW-1:0]        dm_rdata,
    output logic [NUM_RD*DW-1:0] fwd_data,
    output logic                 stall_id,
    output logic                 stall_ex,
    output logic                 err_timeout
`ifdef FWD_PERF_CNT_EN
    ,
    output logic [31:0]          perf_stall_cyc,
    output logic [31:0]          perf_fwd_evt
`endif
);

    localparam int            CW      = $clog2(MAX_WAIT + 1);
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_WAIT);

    fwd_state_e      state;
    logic [AW-1:0]   pend_addr;
    logic            pend_valid;
    logic [CW-1:0]   wait_cnt;

    logic            wait_st;
    logic            load_acc;
    logic            ex_fwd_en;
    logic            ld_fwd_en;
    logic [NUM_RD-1:0] port_hit;
    logic [NUM_RD-1:0] ex_match;
    logic [NUM_RD-1:0] pend_match;

    assign wait_st   = (state == FWD_WAIT);
    assign ex_fwd_en = ex_wr_en & ~ex_dm_read;
    assign ld_fwd_en = wait_st & dm_valid;
    assign load_acc  = ex_dm_read & ~stall_ex;

    // One priority mux per ID read port
    for (genvar g = 0; g < NUM_RD; g++) begin : g_port
        fwd_port_mux #(
            .AW       (AW),
            .DW       (DW),
            .ZERO_REG (ZERO_REG)
        ) u_mux (
            .rd_addr     (rd_addr[g*AW +: AW]),
            .rd_data     (rd_data[g*DW +: DW]),
            .ex_fwd_en   (ex_fwd_en),
            .ex_wr_sel   (ex_wr_sel),
            .ex_wr_addr  (ex_wr_addr),
            .ex_imm      (ex_imm),
            .ex_alu      (ex_alu),
            .ld_fwd_en   (ld_fwd_en),
            .pend_valid  (pend_valid),
            .pend_addr   (pend_addr),
            .dm_rdata    (dm_rdata),
            .mem_wr_en   (mem_wr_en),
            .mem_wr_addr (mem_wr_addr),
            .mem_wr_data (mem_wr_data),
            .wb_wr_en    (wb_wr_en),
            .wb_wr_addr  (wb_wr_addr),
            .wb_wr_data  (wb_wr_data),
            .fwd_data    (fwd_data[g*DW +: DW]),
            .fwd_hit     (port_hit[g]),
            .ex_match    (ex_match[g]),
            .pend_match  (pend_match[g])
        );
    end

    // Stalls: a second load cannot issue while one is still outstanding,
    // and ID must wait for any load result it consumes
    always_comb begin
        stall_ex = wait_st & ~dm_valid & ex_dm_read;
        stall_id = stall_ex
                 | (ex_dm_read & ex_wr_en & (|ex_match))
                 | (wait_st & ~dm_valid & (|pend_match));
    end

    // Outstanding-load tracker with saturating wait counter and sticky timeout
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= FWD_IDLE;
            pend_addr   <= '0;
            pend_valid  <= 1'b0;
            wait_cnt    <= '0;
            err_timeout <= 1'b0;
        end else begin
            case (state)
                FWD_IDLE: begin
                    if (load_acc) begin
                        state      <= FWD_WAIT;
                        pend_addr  <= ex_wr_en ? ex_wr_addr : '0;
                        pend_valid <= ex_wr_en;
                        wait_cnt   <= '0;
                    end
                end
                FWD_WAIT: begin
                    if (dm_valid) begin
                        wait_cnt <= '0;
                        if (load_acc) begin
                            pend_addr  <= ex_wr_en ? ex_wr_addr : '0;
                            pend_valid <= ex_wr_en;
                        end else begin
                            state      <= FWD_IDLE;
                            pend_valid <= 1'b0;
                        end
                    end else begin
                        if (wait_cnt != MAX_CNT) begin
                            wait_cnt <= wait_cnt + CW'(1);
                        end
                        if (wait_cnt >= (MAX_CNT - CW'(1))) begin
                            err_timeout <= 1'b1;
                        end
                    end
                end
                default: state <= FWD_IDLE;
            endcase
        end
    end

`ifdef FWD_PERF_CNT_EN
    // Free-running event counters: stalled ID cycles and forwarding cycles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_stall_cyc <= '0;
            perf_fwd_evt   <= '0;
        end else begin
            if (stall_id) begin
                perf_stall_cyc <= perf_stall_cyc + 32'd1;
            end
            if (|port_hit) begin
                perf_fwd_evt <= perf_fwd_evt + 32'd1;
            end
        end
    end
`else
    logic unused_port_hit;
    assign unused_port_hit = |port_hit;
`endif

endmodule
